// File: rtl/ddr_align_ctrl.sv
// rtl/ddr_align_ctrl.sv - DDR word-alignment controller (optional stats via DDR_ALIGN_STATS_EN)
module ddr_align_ctrl #(
   parameter int                 WIDTH      = 4,
   parameter logic [2*WIDTH-1:0] PATTERN    = 8'hD5,
   parameter int                 LOCK_COUNT = 8,
   parameter int                 TIMEOUT    = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   q1,
   input  logic [WIDTH-1:0]   q2,
   input  logic               realign,
   output logic [2*WIDTH-1:0] out_data,
   output logic               out_valid,
   output logic               locked,
   output logic               phase,
   output logic               timeout,
   output logic [15:0]        lock_events
);

   localparam int CW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST  = CW'(LOCK_COUNT - 1);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_next;
   logic [TW-1:0]      tcnt;
   logic [TW-1:0]      tcnt_next;
   logic               phase_next;
   logic               timeout_next;
   logic               lock_enter;
   logic [WIDTH-1:0]   q2_d;
   logic [2*WIDTH-1:0] cand0;
   logic [2*WIDTH-1:0] cand1;
   logic               m0;
   logic               m1;
   logic               m_held;

   // Two candidate words: same-cycle pair, or straddling the previous falling sample
   always_comb begin
      cand0  = {q2, q1};
      cand1  = {q1, q2_d};
      m0     = (cand0 == PATTERN);
      m1     = (cand1 == PATTERN);
      m_held = phase ? m1 : m0;
   end

   // State, phase and match/timeout counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEARCH;
         cnt   <= '0;
         tcnt  <= '0;
         phase <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         tcnt  <= tcnt_next;
         phase <= phase_next;
      end
   end

   // Next-state logic; realign overrides everything, phase 0 preferred when both match
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      tcnt_next    = tcnt;
      phase_next   = phase;
      timeout_next = 1'b0;
      lock_enter   = 1'b0;
      if (realign) begin
         state_next = SEARCH;
         cnt_next   = '0;
         tcnt_next  = '0;
      end else begin
         case (state)
            SEARCH: begin
               if (m0 || m1) begin
                  phase_next = !m0;
                  tcnt_next  = '0;
                  if (LOCK_COUNT == 1) begin
                     state_next = LOCKED;
                     cnt_next   = '0;
                     lock_enter = 1'b1;
                  end else begin
                     state_next = VERIFY;
                     cnt_next   = CW'(1);
                  end
               end else if (tcnt == TCNT_LAST) begin
                  timeout_next = 1'b1;
                  tcnt_next    = '0;
               end else begin
                  tcnt_next = tcnt + 1'b1;
               end
            end
            VERIFY: begin
               if (m_held) begin
                  if (cnt == CNT_LAST) begin
                     state_next = LOCKED;
                     cnt_next   = '0;
                     lock_enter = 1'b1;
                  end else begin
                     cnt_next = cnt + 1'b1;
                  end
               end else begin
                  state_next = SEARCH;
                  cnt_next   = '0;
               end
            end
            LOCKED: begin
               state_next = LOCKED;
            end
            default: begin
               state_next = SEARCH;
               cnt_next   = '0;
               tcnt_next  = '0;
            end
         endcase
      end
   end

   // Registered outputs; data path follows the phase that will be in effect next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q2_d      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         locked    <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         q2_d      <= q2;
         timeout   <= timeout_next;
         locked    <= (state_next == LOCKED);
         out_valid <= (state_next == LOCKED);
         if (state_next == LOCKED) begin
            out_data <= phase_next ? cand1 : cand0;
         end
      end
   end

`ifdef DDR_ALIGN_STATS_EN
   // Saturating count of lock acquisitions, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_events <= 16'd0;
      end else if (lock_enter && (lock_events != 16'hFFFF)) begin
         lock_events <= lock_events + 16'd1;
      end
   end
`else
   assign lock_events = 16'd0;
`endif

endmodule

// File: tb/tb_ddr_align_ctrl.sv
// tb/tb_ddr_align_ctrl.sv - directed self-checking bench for ddr_align_ctrl
module tb_ddr_align_ctrl;

   logic        clk;
   logic        rst_n;
   logic [3:0]  q1;
   logic [3:0]  q2;
   logic        realign;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        locked;
   logic        phase;
   logic        timeout;
   logic [15:0] lock_events;

   int n_assert = 0;
   int n_fail   = 0;
   logic [15:0] exp_events;

   ddr_align_ctrl #(
      .WIDTH(4),
      .PATTERN(8'hD5),
      .LOCK_COUNT(4),
      .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .q1(q1),
      .q2(q2),
      .realign(realign),
      .out_data(out_data),
      .out_valid(out_valid),
      .locked(locked),
      .phase(phase),
      .timeout(timeout),
      .lock_events(lock_events)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " locked"},      {15'd0, locked},    16'd0);
      check({tag, " out_valid"},   {15'd0, out_valid}, 16'd0);
      check({tag, " out_data"},    {8'd0, out_data},   16'd0);
      check({tag, " phase"},       {15'd0, phase},     16'd0);
      check({tag, " timeout"},     {15'd0, timeout},   16'd0);
      check({tag, " lock_events"}, lock_events,        16'd0);
   endtask

   // Drop reset between clock edges, hold it over one edge, release after that edge
   task automatic async_reset();
      #3;
      rst_n = 1'b0;
      #1;
   endtask

   initial begin
`ifdef DDR_ALIGN_STATS_EN
      exp_events = 16'd2;
`else
      exp_events = 16'd0;
`endif
      rst_n   = 1'b0;
      q1      = 4'h0;
      q2      = 4'h0;
      realign = 1'b0;
      #3;
      check_all_zero("reset");
      tick(2);
      rst_n = 1'b1;

      // Test 1: phase-0 pattern, lock after the 4th match
      q1 = 4'h5;
      q2 = 4'hD;
      tick(3);
      check("t1 locked after 3", {15'd0, locked}, 16'd0);
      check("t1 valid after 3", {15'd0, out_valid}, 16'd0);
      tick(1);
      check("t1 locked", {15'd0, locked}, 16'd1);
      check("t1 valid", {15'd0, out_valid}, 16'd1);
      check("t1 phase", {15'd0, phase}, 16'd0);
      check("t1 data", {8'd0, out_data}, 16'h00D5);

      // Test 5: realign with a simultaneous match drops lock, then relocks
      realign = 1'b1;
      tick(1);
      realign = 1'b0;
      check("t5 locked drop", {15'd0, locked}, 16'd0);
      check("t5 valid drop", {15'd0, out_valid}, 16'd0);
      check("t5 data hold", {8'd0, out_data}, 16'h00D5);
      tick(3);
      check("t5 locked after 3", {15'd0, locked}, 16'd0);
      tick(1);
      check("t5 relocked", {15'd0, locked}, 16'd1);
      check("t5 lock_events", lock_events, exp_events);

      // Test 6a: asynchronous reset while LOCKED
      async_reset();
      check_all_zero("t6 locked-reset");
      tick(1);
      rst_n = 1'b1;

      // Test 2: phase-1 pattern, then straddled word 3A
      q1 = 4'hD;
      q2 = 4'h5;
      tick(4);
      check("t2 locked after 4", {15'd0, locked}, 16'd0);
      tick(1);
      check("t2 locked", {15'd0, locked}, 16'd1);
      check("t2 phase", {15'd0, phase}, 16'd1);
      check("t2 data D5", {8'd0, out_data}, 16'h00D5);
      q2 = 4'hA;
      tick(1);
      check("t2 data before 3A", {8'd0, out_data}, 16'h00D5);
      q1 = 4'h3;
      q2 = 4'h5;
      tick(1);
      check("t2 data 3A", {8'd0, out_data}, 16'h003A);

      // Test 3: two matches, one mismatch, then four matches
      async_reset();
      tick(1);
      rst_n = 1'b1;
      q1 = 4'h5;
      q2 = 4'hD;
      tick(2);
      q1 = 4'h0;
      q2 = 4'h0;
      tick(1);
      check("t3 locked after mismatch", {15'd0, locked}, 16'd0);
      q1 = 4'h5;
      q2 = 4'hD;
      tick(3);
      check("t3 locked after 3", {15'd0, locked}, 16'd0);
      tick(1);
      check("t3 locked", {15'd0, locked}, 16'd1);
      check("t3 data", {8'd0, out_data}, 16'h00D5);

      // Test 6b: asynchronous reset while VERIFY on phase 1
      async_reset();
      tick(1);
      rst_n = 1'b1;
      q1 = 4'hD;
      q2 = 4'h5;
      tick(3);
      check("t6 verify phase", {15'd0, phase}, 16'd1);
      check("t6 verify locked", {15'd0, locked}, 16'd0);
      async_reset();
      check_all_zero("t6 verify-reset");
      tick(1);
      rst_n = 1'b1;

      // Test 4: idle zeros, timeout pulses at cycles 16 and 32
      q1 = 4'h0;
      q2 = 4'h0;
      for (int i = 1; i <= 40; i++) begin
         tick(1);
         check($sformatf("t4 timeout cycle %0d", i), {15'd0, timeout},
               ((i == 16) || (i == 32)) ? 16'd1 : 16'd0);
      end
      check("t4 locked", {15'd0, locked}, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
